sym_packer_10to16: RTL and testbench

- Upstream neighbour of the 16-to-10 unpacker. Packs a stream of 10-bit symbols into contiguous 16-bit words, LSB-first.
- The unpacker reloads its 5-phase counter from the start-of-group marker. This realigns it every 8 symbols (5 words).
- Sits between the symbol source (valid/ready) and the unpacker's data input.

---
 rtl/sym_gearbox_pkg.sv | 18 +
 rtl/sym_packer_10to16.sv | 110 +++++++++++
 tb/tb_sym_packer_10to16.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sym_gearbox_pkg.sv
// Shared constants and types for the 10-bit symbol <-> 16-bit word gearbox pair
// (this packer and the downstream unpacker).
package sym_gearbox_pkg;

    localparam int unsigned SYM_W       = 10;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned GROUP_WORDS = 5;
    localparam int unsigned GROUP_SYMS  = 8;

    // Accumulator holds one full word plus one incoming symbol.
    localparam int unsigned ACC_W  = SYM_W + WORD_W;
    localparam int unsigned FILL_W = 5;
    localparam int unsigned WCNT_W = 3;

    typedef logic [SYM_W-1:0]  sym_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/sym_packer_10to16.sv
// Packs 10-bit symbols LSB-first into 16-bit words, marking word 0 of every 5-word group.
// Optional SYM_PACKER_FLUSH_EN adds a flush input that zero-pads the tail to a word boundary.
module sym_packer_10to16
    import sym_gearbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SYM_W-1:0]  in_sym,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sog
`ifdef SYM_PACKER_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    logic              pop;
    logic              push;
    logic [FILL_W-1:0] fill_ap;
    logic [ACC_W-1:0]  acc_shift;
    logic [WCNT_W-1:0] wcnt_inc;

`ifdef SYM_PACKER_FLUSH_EN
    logic pad_q, pad_d;
    logic flush_busy;
    logic pad_now;
`endif

    assign out_word  = acc_q[WORD_W-1:0];
    assign out_valid = (fill_q >= FILL_W'(WORD_W));
    assign out_sog   = (wcnt_q == '0);

    // Handshake: pop is evaluated first so in_ready sees the space it frees.
    always_comb begin
        pop       = out_valid && out_ready;
        fill_ap   = pop ? (fill_q - FILL_W'(WORD_W)) : fill_q;
        acc_shift = pop ? (acc_q >> WORD_W) : acc_q;
        in_ready  = (fill_ap <= FILL_W'(ACC_W - SYM_W));
`ifdef SYM_PACKER_FLUSH_EN
        flush_busy = flush && (fill_q != '0);
        pad_now    = flush && (fill_ap != '0) && (fill_ap < FILL_W'(WORD_W));
        if (flush_busy) begin
            in_ready = 1'b0;
        end
`endif
        push = in_valid && in_ready;
    end

    // Next state: shift out the popped word, then insert at the post-shift fill.
    always_comb begin
        wcnt_inc = (wcnt_q == WCNT_W'(GROUP_WORDS - 1)) ? '0 : (wcnt_q + WCNT_W'(1));
        acc_d    = acc_shift;
        fill_d   = fill_ap;
        wcnt_d   = pop ? wcnt_inc : wcnt_q;
`ifdef SYM_PACKER_FLUSH_EN
        pad_d    = pad_q;
`endif
        if (push) begin
            acc_d  = acc_shift | (ACC_W'(in_sym) << fill_ap);
            fill_d = fill_ap + FILL_W'(SYM_W);
        end
`ifdef SYM_PACKER_FLUSH_EN
        // Bits above fill are always zero, so padding only bumps the fill count.
        if (pad_now) begin
            fill_d = FILL_W'(WORD_W);
            pad_d  = 1'b1;
        end else if (pad_q && pop && (fill_ap == '0)) begin
            wcnt_d = '0;
            pad_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            fill_q <= '0;
            wcnt_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            wcnt_q <= wcnt_d;
        end
    end

`ifdef SYM_PACKER_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= pad_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fill_q <= FILL_W'(ACC_W));
        end
    end

endmodule

// File: tb/tb_sym_packer_10to16.sv
// Randomized and directed bench for sym_packer_10to16 against a bit-queue stream model.
// Define SYM_PACKER_FLUSH_EN on both RTL and bench to exercise the flush port.
module tb_sym_packer_10to16;

    logic        clk;
    logic        rst;
    logic [9:0]  in_sym;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_sog;
    logic        flush_i;

    sym_packer_10to16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_sym    (in_sym),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sog   (out_sog)
`ifdef SYM_PACKER_FLUSH_EN
        ,
        .flush     (flush_i)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;

    // Stream model: pending bits in arrival order, and words emitted since group start.
    bit         mq[$];
    int         words_popped;
    bit         pad_flag;
    // Receive side: a reference unpacker fed with the DUT's popped words.
    bit         rxq[$];
    int         rx_cnt;
    bit         rx_en;
    logic [9:0] tx_q[$];
    logic [9:0] sent_q[$];
    logic [15:0] rec_words[$];
    bit         rec_sog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        mq.delete();
        rxq.delete();
        sent_q.delete();
        tx_q.delete();
        rec_words.delete();
        rec_sog.delete();
        words_popped = 0;
        pad_flag     = 1'b0;
        rx_cnt       = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // One clock: drive, compare every output against the model, then advance the model.
    task automatic step(input bit iv, input logic [9:0] sym, input bit ordy, output bit pushed);
        bit          exp_valid, exp_pop, exp_rdy, flush_act;
        int          fill_ap;
        logic [15:0] exp_word;
        logic [9:0]  s;
        in_valid  = iv;
        in_sym    = sym;
        out_ready = ordy;
        #1;
        exp_valid = (mq.size() >= 16);
        exp_pop   = exp_valid && ordy;
        fill_ap   = mq.size() - (exp_pop ? 16 : 0);
        flush_act = flush_i && (mq.size() != 0);
        exp_rdy   = (fill_ap + 10 <= 26) && !flush_act;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_valid) begin
            exp_word = '0;
            for (int i = 0; i < 16; i++) exp_word[i] = mq[i];
            chk("out_word", 32'(out_word), 32'(exp_word));
            chk("out_sog", 32'(out_sog), 32'((words_popped % 5) == 0));
        end
        pushed = iv && exp_rdy;
        if (exp_pop) begin
            rec_words.push_back(out_word);
            rec_sog.push_back(out_sog);
            if (rx_en) begin
                if (out_sog) begin
                    chk("rx_sog_align", 32'(rxq.size()), 32'd0);
                    chk("rx_sog_group", 32'(rx_cnt % 8), 32'd0);
                end
                for (int i = 0; i < 16; i++) rxq.push_back(out_word[i]);
                while (rxq.size() >= 10) begin
                    for (int i = 0; i < 10; i++) s[i] = rxq.pop_front();
                    if (sent_q.size() == 0) begin
                        chk("rx_extra_sym", 32'(s), 32'h7FFFFFFF);
                    end else begin
                        chk("rx_sym", 32'(s), 32'(sent_q.pop_front()));
                    end
                    rx_cnt++;
                end
            end
        end
        @(posedge clk);
        if (exp_pop) begin
            for (int i = 0; i < 16; i++) void'(mq.pop_front());
            if (pad_flag && mq.size() == 0) begin
                words_popped = 0;
                pad_flag     = 1'b0;
            end else begin
                words_popped++;
            end
        end
        if (flush_i && mq.size() > 0 && mq.size() < 16) begin
            while (mq.size() < 16) mq.push_back(1'b0);
            pad_flag = 1'b1;
        end
        if (pushed) begin
            for (int i = 0; i < 10; i++) mq.push_back(sym[i]);
        end
        @(negedge clk);
    endtask

    // Feed tx_q and drain all complete words with the given valid/ready probabilities.
    task automatic pump(input int vprob, input int rprob, input int budget);
        int         c;
        bit         iv, ordy, pushed;
        logic [9:0] s;
        c = 0;
        while ((tx_q.size() != 0 || mq.size() >= 16) && c < budget) begin
            iv   = (tx_q.size() != 0) && (int'($urandom_range(99)) < vprob);
            ordy = (int'($urandom_range(99)) < rprob);
            s    = (tx_q.size() != 0) ? tx_q[0] : 10'(($urandom));
            step(iv, s, ordy, pushed);
            if (pushed) sent_q.push_back(tx_q.pop_front());
            c++;
        end
        if (c >= budget) chk("pump_timeout", 32'(c), 32'(budget - 1));
    endtask

    int n_sog;
    bit pushed;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rx_en  = 1'b1;
        in_sym = '0;
        @(negedge clk);
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sog", 32'(out_sog), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Ascending symbols, full rate
        for (int i = 1; i <= 8; i++) tx_q.push_back(10'(i));
        pump(100, 100, 100);
        chk("seq_words", 32'(rec_words.size()), 32'd5);
        chk("seq_word0", 32'(rec_words[0]), 32'h0801);
        chk("seq_word1", 32'(rec_words[1]), 32'h0030);
        chk("seq_word2", 32'(rec_words[2]), 32'h0501);
        n_sog = 0;
        foreach (rec_sog[i]) n_sog += int'(rec_sog[i]);
        chk("seq_sog_cnt", 32'(n_sog), 32'd1);
        chk("seq_sog0", 32'(rec_sog[0]), 32'd1);
        chk("seq_empty", 32'(out_valid), 32'd0);

        // All-ones group followed by all-zeros group
        rec_words.delete();
        rec_sog.delete();
        for (int i = 0; i < 8; i++) tx_q.push_back(10'h3FF);
        for (int i = 0; i < 8; i++) tx_q.push_back(10'h000);
        pump(100, 100, 100);
        chk("ones_words", 32'(rec_words.size()), 32'd10);
        for (int i = 0; i < 5; i++) chk("ones_word", 32'(rec_words[i]), 32'hFFFF);
        chk("zeros_word", 32'(rec_words[7]), 32'h0000);
        chk("ones_sog5", 32'(rec_sog[5]), 32'd1);
        n_sog = 0;
        foreach (rec_sog[i]) n_sog += int'(rec_sog[i]);
        chk("ones_sog_cnt", 32'(n_sog), 32'd2);

        // Backpressure: third symbol refused, word held
        rec_words.delete();
        for (int i = 1; i <= 4; i++) tx_q.push_back(10'(i));
        for (int c = 0; c < 5; c++) begin
            step(1'b1, tx_q[0], 1'b0, pushed);
            if (pushed) sent_q.push_back(tx_q.pop_front());
        end
        chk("hold_accepted", 32'(tx_q.size()), 32'd2);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_word", 32'(out_word), 32'h0801);
        chk("hold_sog", 32'(out_sog), 32'd1);
        for (int i = 5; i <= 8; i++) tx_q.push_back(10'(i));
        pump(100, 100, 100);
        chk("hold_resume_words", 32'(rec_words.size()), 32'd5);
        chk("hold_resume_w1", 32'(rec_words[1]), 32'h0030);

        // Reset mid-stream after three symbols
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 10'(i), 1'b1, pushed);
            sent_q.push_back(10'(i));
        end
        do_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) tx_q.push_back(10'(i * 37 + 5));
        pump(100, 100, 100);
        chk("mid_rst_sog", 32'(rec_sog[0]), 32'd1);
        chk("mid_rst_words", 32'(rec_words.size()), 32'd5);

        // Random traffic through the reference unpacker
        do_reset();
        for (int i = 0; i < 10000; i++) tx_q.push_back(10'($urandom));
        pump(70, 70, 60000);
        chk("rand_syms", 32'(rx_cnt), 32'd10000);
        chk("rand_left", 32'(sent_q.size()), 32'd0);

`ifdef SYM_PACKER_FLUSH_EN
        // Flush: 30 bits become one full word plus a zero-padded tail word
        do_reset();
        rx_en = 1'b0;
        for (int i = 0; i < 3; i++) tx_q.push_back(10'h3FF);
        pump(100, 100, 100);
        flush_i = 1'b1;
        step(1'b1, 10'h155, 1'b0, pushed);
        chk("flush_refuse", 32'(pushed), 32'd0);
        flush_i = 1'b0;
        pump(100, 100, 100);
        chk("flush_words", 32'(rec_words.size()), 32'd2);
        chk("flush_w0", 32'(rec_words[0]), 32'hFFFF);
        chk("flush_w1", 32'(rec_words[1]), 32'h3FFF);
        tx_q.push_back(10'h001);
        tx_q.push_back(10'h002);
        pump(100, 100, 100);
        chk("flush_next_sog", 32'(rec_sog[2]), 32'd1);
        chk("flush_next_word", 32'(rec_words[2]), 32'h0801);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
